// File: rtl/merge21_arb.sv
// Two-to-one merge arbiter: forwards a packet from In0 or In1 onto Out and
// reports the winning source index on S; round-robin or fixed priority.
//
//  state | meaning
//  IDLE  | arbitrate between valid inputs, accept the winner
//  SEND  | hold captured packet on Out and source on S until both handshake
module merge21_arb #(
    parameter int W     = 9,
    parameter bit RR_EN = 1'b1
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] In0_data,
    input  logic         In0_valid,
    output logic         In0_ready,
    input  logic [W-1:0] In1_data,
    input  logic         In1_valid,
    output logic         In1_ready,
    output logic [W-1:0] Out_data,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic         S_data,
    output logic         S_valid,
    input  logic         S_ready
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] data_reg;
    logic         src_reg;
    logic         last_grant;
    logic         done_out;
    logic         done_s;

    logic         winner;
    logic         accept;
    logic         out_fire;
    logic         s_fire;

    always_comb begin
        winner = 1'b0;
        if (RR_EN && In0_valid && In1_valid) begin
            winner = ~last_grant;
        end else if (!In0_valid && In1_valid) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        In0_ready = 1'b0;
        In1_ready = 1'b0;
        Out_valid = 1'b0;
        S_valid   = 1'b0;
        accept    = 1'b0;
        out_fire  = 1'b0;
        s_fire    = 1'b0;
        case (state)
            IDLE: begin
                accept    = In0_valid | In1_valid;
                In0_ready = accept & ~winner;
                In1_ready = accept & winner;
                if (accept) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                Out_valid = ~done_out;
                S_valid   = ~done_s;
                out_fire  = Out_valid & Out_ready;
                s_fire    = S_valid & S_ready;
                // Leave only once both consumers have taken their copy.
                if ((done_out | out_fire) && (done_s | s_fire)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Out_data = data_reg;
    assign S_data   = src_reg;

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state      <= IDLE;
            data_reg   <= '0;
            src_reg    <= 1'b0;
            last_grant <= 1'b1;
            done_out   <= 1'b0;
            done_s     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (accept) begin
                    data_reg   <= winner ? In1_data : In0_data;
                    src_reg    <= winner;
                    last_grant <= winner;
                    done_out   <= 1'b0;
                    done_s     <= 1'b0;
                end
            end else begin
                done_out <= done_out | out_fire;
                done_s   <= done_s | s_fire;
            end
        end
    end

endmodule
